// File: rtl/ladybird_mem_arbiter_pkg.sv
// ladybird_config: shared configuration for the ladybird core slice.
// Holds the default datapath width, the arbiter FSM state and owner
// encodings, and the funct3 value used for instruction fetches
// (a full 32-bit word access).
package ladybird_config;

  localparam int XLEN = 32;

  localparam logic [2:0] FETCH_FUNCT3 = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } arb_owner_t;

endpackage

// File: rtl/ladybird_mem_arbiter_if.sv
// Downstream memory bus of the ladybird arbiter.
//   master : arbiter side. It drives the request (m_valid, m_addr, m_data,
//            m_we, m_funct) and receives m_ready, m_rvalid and m_rdata.
//   slave  : memory side, with the opposite directions.
interface ladybird_mem_arbiter_if #(
  parameter int XLEN = 32
);
  logic            m_valid;
  logic            m_ready;
  logic [XLEN-1:0] m_addr;
  logic [XLEN-1:0] m_data;
  logic            m_we;
  logic [2:0]      m_funct;
  logic            m_rvalid;
  logic [XLEN-1:0] m_rdata;

  modport master (
    output m_valid, m_addr, m_data, m_we, m_funct,
    input  m_ready, m_rvalid, m_rdata
  );

  modport slave (
    input  m_valid, m_addr, m_data, m_we, m_funct,
    output m_ready, m_rvalid, m_rdata
  );
endinterface

// File: rtl/ladybird_mem_arbiter.sv
// ladybird_mem_arbiter: shares one memory port between instruction fetch
// and load/store traffic. Only one transaction is outstanding at a time.
// Ports:
//   clk, nrst               clock and synchronous active-low reset
//   i_if_valid/ready/addr   fetch request; o_if_valid/o_if_data is the response
//   i_flush                 drops an in-flight fetch response
//   i_d_valid/ready/addr/data/we/funct  load/store request;
//                           o_d_valid/o_d_data is the response
//   mem                     downstream bus (master modport)
// Data wins arbitration, except that after MAX_DATA_STREAK consecutive data
// grants taken while fetch was waiting, fetch is served once.
module ladybird_mem_arbiter
  import ladybird_config::*;
#(
  parameter int XLEN            = ladybird_config::XLEN,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   i_if_valid,
  output logic                   i_if_ready,
  input  logic [XLEN-1:0]        i_if_addr,
  output logic                   o_if_valid,
  output logic [XLEN-1:0]        o_if_data,
  input  logic                   i_flush,
  input  logic                   i_d_valid,
  output logic                   i_d_ready,
  input  logic [XLEN-1:0]        i_d_addr,
  input  logic [XLEN-1:0]        i_d_data,
  input  logic                   i_d_we,
  input  logic [2:0]             i_d_funct,
  output logic                   o_d_valid,
  output logic [XLEN-1:0]        o_d_data,
  ladybird_mem_arbiter_if.master mem
);

  localparam int SW = $clog2(MAX_DATA_STREAK + 1);

  arb_state_t      state, state_nx;
  arb_owner_t      owner;
  logic [SW-1:0]   streak;
  logic            drop;
  logic [XLEN-1:0] addr_q, data_q;
  logic            we_q;
  logic [2:0]      funct_q;
  logic            sel_d, streak_full;

  // Selection is only meaningful in IDLE, and the readies are gated by
  // state. Each ready also needs its valid, so the two can never be high
  // together.
  assign streak_full = (streak == SW'(MAX_DATA_STREAK));
  assign sel_d       = i_d_valid && !(i_if_valid && streak_full);
  assign i_d_ready   = (state == ST_IDLE) && sel_d;
  assign i_if_ready  = (state == ST_IDLE) && i_if_valid && !sel_d;

  assign mem.m_valid = (state == ST_REQ);
  assign mem.m_addr  = addr_q;
  assign mem.m_data  = data_q;
  assign mem.m_we    = we_q;
  assign mem.m_funct = funct_q;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (i_d_ready || i_if_ready) state_nx = ST_REQ;
      ST_REQ:  if (mem.m_ready)             state_nx = ST_RESP;
      ST_RESP: if (mem.m_rvalid)            state_nx = ST_IDLE;
      default:                              state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state      <= ST_IDLE;
      owner      <= OWN_IF;
      streak     <= '0;
      drop       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      funct_q    <= '0;
      o_if_valid <= 1'b0;
      o_if_data  <= '0;
      o_d_valid  <= 1'b0;
      o_d_data   <= '0;
    end else begin
      state      <= state_nx;
      o_if_valid <= 1'b0;
      o_d_valid  <= 1'b0;

      if (i_d_ready) begin
        owner   <= OWN_D;
        addr_q  <= i_d_addr;
        data_q  <= i_d_data;
        we_q    <= i_d_we;
        funct_q <= i_d_funct;
        // The streak counts only data grants that make fetch wait.
        if (i_if_valid && !streak_full) streak <= streak + SW'(1);
      end else if (i_if_ready) begin
        owner   <= OWN_IF;
        addr_q  <= i_if_addr;
        data_q  <= '0;
        we_q    <= 1'b0;
        funct_q <= FETCH_FUNCT3;
        streak  <= '0;
      end

      // A fetch redirected while in flight still completes downstream.
      // Only its response is swallowed.
      if (state != ST_IDLE && owner == OWN_IF && i_flush) drop <= 1'b1;

      if (state == ST_RESP && mem.m_rvalid) begin
        drop <= 1'b0;
        if (owner == OWN_D) begin
          o_d_valid <= 1'b1;
          o_d_data  <= mem.m_rdata;
        end else if (!(drop || i_flush)) begin
          o_if_valid <= 1'b1;
          o_if_data  <= mem.m_rdata;
        end
      end
    end
  end

endmodule
